regfile_writeback_queue: RTL and testbench

//  Initiator side of the 64-bit x 32 register bank write port: buffers results from execute/memory stages
//  and drains them into the bank's write_register/write_data/register_write inputs, one write per cycle.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/wbq_bypass_match.sv | 33 +++
 rtl/regfile_writeback_queue.sv | 119 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-bank definitions: address/data widths, register count and the queued write entry type.
package regfile_pkg;
  localparam int REG_AW    = 5;
  localparam int REG_DW    = 64;
  localparam int REG_COUNT = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wbq_bypass_match.sv
// Per-read-port forwarding lookup: scans queued entries oldest to youngest so the youngest match wins.
module wbq_bypass_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    addr_arr_i [DEPTH],
  input  logic [DW-1:0]    data_arr_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PW-1:0]    head_i,
  input  logic [AW-1:0]    query_i,
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);

  logic [PW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      // x0 is never stored, but the query itself must also never hit on zero
      if (valid_i[idx] && (addr_arr_i[idx] == query_i) && (query_i != '0)) begin
        hit_o  = 1'b1;
        data_o = data_arr_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO draining into the register bank write port, one write per cycle.
// Define REGFILE_WBQ_BYPASS_EN to enable forwarding of pending entries on the byp_* ports.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic [AW-1:0]            write_register,
  output logic [DW-1:0]            write_data,
  output logic                     register_write,
  output logic [$clog2(DEPTH):0]   level,
  input  logic [AW-1:0]            byp_addr_one,
  input  logic [AW-1:0]            byp_addr_two,
  output logic                     byp_hit_one,
  output logic                     byp_hit_two,
  output logic [DW-1:0]            byp_data_one,
  output logic [DW-1:0]            byp_data_two
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign level    = level_q;
  assign in_ready = (level_q != LW'(DEPTH));
  // Held off during reset so a pre-reset head never reaches the bank
  assign register_write = (level_q != '0) && drain_en && !reset;
  assign write_register = register_write ? addr_q[rd_ptr_q] : '0;
  assign write_data     = register_write ? data_q[rd_ptr_q] : '0;

  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = register_write;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef REGFILE_WBQ_BYPASS_EN
  logic [DEPTH-1:0] valid_mask;
  logic [PW-1:0]    offs;

  always_comb begin
    valid_mask = '0;
    offs       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs          = PW'(i) - rd_ptr_q;
      valid_mask[i] = !reset && ({1'b0, offs} < level_q);
    end
  end

  wbq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_byp_one (
    .addr_arr_i (addr_q),
    .data_arr_i (data_q),
    .valid_i    (valid_mask),
    .head_i     (rd_ptr_q),
    .query_i    (byp_addr_one),
    .hit_o      (byp_hit_one),
    .data_o     (byp_data_one)
  );

  wbq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_byp_two (
    .addr_arr_i (addr_q),
    .data_arr_i (data_q),
    .valid_i    (valid_mask),
    .head_i     (rd_ptr_q),
    .query_i    (byp_addr_two),
    .hit_o      (byp_hit_two),
    .data_o     (byp_data_two)
  );
`else
  logic unused_byp;
  assign unused_byp   = ^{byp_addr_one, byp_addr_two};
  assign byp_hit_one  = 1'b0;
  assign byp_hit_two  = 1'b0;
  assign byp_data_one = '0;
  assign byp_data_two = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed vector bench for regfile_writeback_queue; bypass expectations follow REGFILE_WBQ_BYPASS_EN.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [63:0] in_data;
  logic        drain_en;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic        register_write;
  logic [2:0]  level;
  logic [4:0]  byp_addr_one, byp_addr_two;
  logic        byp_hit_one, byp_hit_two;
  logic [63:0] byp_data_one, byp_data_two;

  always #5 clk = ~clk;

  regfile_writeback_queue dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .drain_en       (drain_en),
    .write_register (write_register),
    .write_data     (write_data),
    .register_write (register_write),
    .level          (level),
    .byp_addr_one   (byp_addr_one),
    .byp_addr_two   (byp_addr_two),
    .byp_hit_one    (byp_hit_one),
    .byp_hit_two    (byp_hit_two),
    .byp_data_one   (byp_data_one),
    .byp_data_two   (byp_data_two)
  );

  typedef struct {
    bit          rst;
    bit          v;
    logic [4:0]  a;
    logic [63:0] d;
    bit          de;
    logic [4:0]  b1;
    logic [4:0]  b2;
    bit          e_rdy;
    logic [2:0]  e_lvl;
    bit          e_we;
    logic [4:0]  e_wr;
    logic [63:0] e_wd;
    bit          e_h1;
    logic [63:0] e_d1;
    bit          e_h2;
    logic [63:0] e_d2;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(bit rst, bit v, logic [4:0] a, logic [63:0] d, bit de,
                     logic [4:0] b1, logic [4:0] b2,
                     bit e_rdy, logic [2:0] e_lvl, bit e_we, logic [4:0] e_wr, logic [63:0] e_wd,
                     bit e_h1, logic [63:0] e_d1, bit e_h2, logic [63:0] e_d2);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.d = d; t.de = de; t.b1 = b1; t.b2 = b2;
    t.e_rdy = e_rdy; t.e_lvl = e_lvl; t.e_we = e_we; t.e_wr = e_wr; t.e_wd = e_wd;
`ifdef REGFILE_WBQ_BYPASS_EN
    t.e_h1 = e_h1; t.e_d1 = e_d1; t.e_h2 = e_h2; t.e_d2 = e_d2;
`else
    t.e_h1 = 1'b0; t.e_d1 = '0; t.e_h2 = 1'b0; t.e_d2 = '0;
    if (e_h1 || e_h2 || (e_d1 != '0) || (e_d2 != '0)) t.e_h1 = 1'b0;
`endif
    vecs.push_back(t);
  endtask

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit v, logic [4:0] a, logic [63:0] d, bit de, logic [4:0] b1, logic [4:0] b2);
    reset = rst; in_valid = v; in_addr = a; in_data = d; drain_en = de;
    byp_addr_one = b1; byp_addr_two = b2;
  endtask

  initial begin
    int got;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_level", -1, 64'(level), 0);
    chk("reset_ready", -1, 64'(in_ready), 1);
    chk("reset_we", -1, 64'(register_write), 0);
    chk("reset_wr", -1, 64'(write_register), 0);
    chk("reset_wd", -1, write_data, 0);
    chk("reset_hit", -1, 64'({byp_hit_one, byp_hit_two}), 0);
    @(posedge clk); #1;

    // single write, one-cycle latency
    add(0,1,3,64'hA5,1,0,0, 1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,1,1,3,64'hA5, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,0,0,0,0, 0,0,0,0);
    // fill with drain held, full refuses input even while draining
    add(0,1,1,64'h11,0,0,0, 1,0,0,0,0, 0,0,0,0);
    add(0,1,2,64'h12,0,0,0, 1,1,0,0,0, 0,0,0,0);
    add(0,1,3,64'h13,0,0,0, 1,2,0,0,0, 0,0,0,0);
    add(0,1,4,64'h14,0,0,0, 1,3,0,0,0, 0,0,0,0);
    add(0,1,5,64'h55,0,0,0, 0,4,0,0,0, 0,0,0,0);
    add(0,1,5,64'h55,1,0,0, 0,4,1,1,64'h11, 0,0,0,0);
    add(0,1,5,64'h55,0,0,0, 1,3,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,0,0,      0,4,1,2,64'h12, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,3,1,3,64'h13, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,2,1,4,64'h14, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,1,1,5,64'h55, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,0,0,0,0, 0,0,0,0);
    // x0 write discarded
    add(0,1,0,64'hFF,1,0,0, 1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,0,0,      1,0,0,0,0, 0,0,0,0);
    // forwarding: youngest wins, draining entry still pending, x0 never hits
    add(0,1,7,64'h11,0,7,9, 1,0,0,0,0, 0,0,0,0);
    add(0,1,7,64'h22,0,7,9, 1,1,0,0,0, 1,64'h11,0,0);
    add(0,1,9,64'h33,0,7,9, 1,2,0,0,0, 1,64'h22,0,0);
    add(0,0,0,0,0,7,8,      1,3,0,0,0, 1,64'h22,0,0);
    add(0,0,0,0,0,7,9,      1,3,0,0,0, 1,64'h22,1,64'h33);
    add(0,0,0,0,1,7,0,      1,3,1,7,64'h11, 1,64'h22,0,0);
    add(0,0,0,0,1,7,9,      1,2,1,7,64'h22, 1,64'h22,1,64'h33);
    add(0,0,0,0,1,7,9,      1,1,1,9,64'h33, 0,0,1,64'h33);
    add(0,0,0,0,1,7,9,      1,0,0,0,0, 0,0,0,0);
    // reset with three entries queued
    add(0,1,1,64'hA1,0,2,3, 1,0,0,0,0, 0,0,0,0);
    add(0,1,2,64'hA2,0,2,3, 1,1,0,0,0, 0,0,0,0);
    add(0,1,3,64'hA3,0,2,3, 1,2,0,0,0, 1,64'hA2,0,0);
    add(1,0,0,0,1,2,3,      1,3,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,2,3,      1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,2,3,      1,0,0,0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].de, vecs[i].b1, vecs[i].b2);
      @(negedge clk);
      chk("in_ready", i, 64'(in_ready), 64'(vecs[i].e_rdy));
      chk("level", i, 64'(level), 64'(vecs[i].e_lvl));
      chk("register_write", i, 64'(register_write), 64'(vecs[i].e_we));
      chk("write_register", i, 64'(write_register), 64'(vecs[i].e_wr));
      chk("write_data", i, write_data, vecs[i].e_wd);
      chk("byp_hit_one", i, 64'(byp_hit_one), 64'(vecs[i].e_h1));
      chk("byp_data_one", i, byp_data_one, vecs[i].e_d1);
      chk("byp_hit_two", i, 64'(byp_hit_two), 64'(vecs[i].e_h2));
      chk("byp_data_two", i, byp_data_two, vecs[i].e_d2);
      @(posedge clk); #1;
    end

    // back-to-back streaming across pointer wrap: each write appears one cycle after its push
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 5'(i + 1), 64'h100 + 64'(i), 1, 0, 0);
      @(negedge clk);
      if (i == 0) begin
        chk("stream_we0", i, 64'(register_write), 0);
      end else begin
        chk("stream_wr", i, 64'(write_register), 64'(i));
        chk("stream_wd", i, write_data, 64'h100 + 64'(i - 1));
        chk("stream_lvl", i, 64'(level), 1);
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("stream_last_wr", 10, 64'(write_register), 10);
    @(posedge clk); #1;

    // fill while held, then drain with a bounded wait
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'(10 + i), 64'hB0 + 64'(i), 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (register_write) begin
        chk("drain_order_wr", got, 64'(write_register), 64'(10 + got));
        chk("drain_order_wd", got, write_data, 64'hB0 + 64'(got));
        got++;
      end
      @(posedge clk); #1;
    end
    chk("drain_count", 0, 64'(got), 4);
    chk("drain_end_level", 0, 64'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
